// File: rtl/lod_pkg.sv
// Shared definitions for the leading-one detector: behavioural reference,
// sentinel constant and parameter legality check.
package lod_pkg;

  localparam int LOD_MAX_WIDTH = 64;

  // Value reported when no bit is set: all ones at the given index width.
  function automatic logic [63:0] lod_sentinel(input int idx_w);
    return (64'd1 << idx_w) - 64'd1;
  endfunction

  // The sentinel must not collide with any legal bit position.
  function automatic bit lod_params_ok(input int width, input int idx_w);
    if (width < 2 || width > LOD_MAX_WIDTH) return 1'b0;
    if (idx_w < 1 || idx_w > 31) return 1'b0;
    return (64'd1 << idx_w) > 64'(width);
  endfunction

  // Behavioural reference: position of the highest set bit, or -1 for zero.
  function automatic int lod_ref(input logic [63:0] a, input int width);
    for (int j = width - 1; j >= 0; j--) begin
      if (a[j]) return j;
    end
    return -1;
  endfunction

endpackage

// File: rtl/lod_encoder.sv
// Combinational priority encoder built as a balanced tree of valid/index
// merges; input is zero-padded up to the next power of two.
module lod_encoder
  import lod_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] a,
  output logic [IDX_W-1:0] index,
  output logic             zero
);

  localparam int LVL = $clog2(WIDTH);
  localparam int P   = 1 << LVL;
  localparam logic [IDX_W-1:0] SENTINEL = IDX_W'(lod_sentinel(IDX_W));

  logic [P-1:0] w_a_pad;
  assign w_a_pad = P'(a);

  for (genvar gi = 0; gi <= LVL; gi++) begin : g_lvl
    localparam int N = P >> gi;
    logic           w_v   [N];
    logic [LVL-1:0] w_idx [N];

    if (gi == 0) begin : g_leaf
      for (genvar gj = 0; gj < N; gj++) begin : g_node
        assign w_v[gj]   = w_a_pad[gj];
        assign w_idx[gj] = '0;
      end
    end else begin : g_merge
      // Upper child wins; its subtree position supplies the new index bit.
      for (genvar gj = 0; gj < N; gj++) begin : g_node
        localparam logic [LVL-1:0] HI_BIT = LVL'(1) << (gi - 1);
        assign w_v[gj]   = g_lvl[gi-1].w_v[2*gj+1] | g_lvl[gi-1].w_v[2*gj];
        assign w_idx[gj] = g_lvl[gi-1].w_v[2*gj+1]
                         ? (g_lvl[gi-1].w_idx[2*gj+1] | HI_BIT)
                         : g_lvl[gi-1].w_idx[2*gj];
      end
    end
  end

  assign zero  = ~g_lvl[LVL].w_v[0];
  assign index = zero ? SENTINEL : IDX_W'(g_lvl[LVL].w_idx[0]);

endmodule

// File: rtl/leading_one_detect.sv
// Registered leading-one detector: tree encoder followed by a single
// output stage with a valid qualifier.
module leading_one_detect
  import lod_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic [IDX_W-1:0] index,
  output logic             zero
);

  localparam logic [IDX_W-1:0] SENTINEL = IDX_W'(lod_sentinel(IDX_W));

  if (!lod_params_ok(WIDTH, IDX_W)) begin : g_param_check
    $error("leading_one_detect: illegal WIDTH/IDX_W combination");
  end

  logic [IDX_W-1:0] w_index;
  logic             w_zero;

  lod_encoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_encoder (
    .a     (a),
    .index (w_index),
    .zero  (w_zero)
  );

  logic             r_valid;
  logic [IDX_W-1:0] r_index;
  logic             r_zero;

  // Result fields only load on accepted words so they hold across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_index <= SENTINEL;
      r_zero  <= 1'b1;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_index <= w_index;
        r_zero  <= w_zero;
      end
    end
  end

  assign out_valid = r_valid;
  assign index     = r_index;
  assign zero      = r_zero;

endmodule

// File: tb/tb_leading_one_detect.sv
// Directed and exhaustive checks of the registered leading-one detector
// at the default width plus two other parameterisations.
module tb_leading_one_detect;
  import lod_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [8:0] a = '0;
  logic       out_valid;
  logic [4:0] index;
  logic       zero;

  logic        in_valid16 = 1'b0;
  logic [15:0] a16 = '0;
  logic        out_valid16;
  logic [4:0]  index16;
  logic        zero16;

  logic       in_valid2 = 1'b0;
  logic [1:0] a2 = '0;
  logic       out_valid2;
  logic [1:0] index2;
  logic       zero2;

  leading_one_detect #(.WIDTH(9), .IDX_W(5)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .index     (index),
    .zero      (zero)
  );

  leading_one_detect #(.WIDTH(16), .IDX_W(5)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .a         (a16),
    .out_valid (out_valid16),
    .index     (index16),
    .zero      (zero16)
  );

  leading_one_detect #(.WIDTH(2), .IDX_W(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .a         (a2),
    .out_valid (out_valid2),
    .index     (index2),
    .zero      (zero2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word, advance one edge, check the registered result.
  task automatic vec(input string tag, input logic [8:0] val, input logic [4:0] exp_idx,
                     input logic exp_zero);
    in_valid = 1'b1;
    a        = val;
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_index"}, 64'(index), 64'(exp_idx));
    check({tag, "_zero"},  64'(zero), 64'(exp_zero));
    $display("[TB] %s a=%03h index=%0d zero=%0d", tag, val, index, zero);
  endtask

  logic [8:0] word;
  int         ref_idx;

  initial begin
    // Reset held with a live input: nothing must be captured.
    in_valid = 1'b1;
    a        = 9'h1FF;
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_index", 64'(index), 64'h1F);
    check("rst_zero",  64'(zero), 64'd1);
    check("rst_valid16", 64'(out_valid16), 64'd0);
    check("rst_index2",  64'(index2), 64'h3);
    rst_n = 1'b1;

    vec("zero_word", 9'h000, 5'h1F, 1'b1);
    vec("bit0",      9'h001, 5'd0,  1'b0);
    vec("bit8",      9'h100, 5'd8,  1'b0);
    vec("all_ones",  9'h1FF, 5'd8,  1'b0);
    vec("prio_5",    9'b000101100, 5'd5, 1'b0);
    vec("prio_7",    9'b011111111, 5'd7, 1'b0);
    vec("prio_1",    9'b000000011, 5'd1, 1'b0);

    // Asynchronous reset mid-stream, sampled between clock edges.
    vec("pre_rst", 9'h040, 5'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_index", 64'(index), 64'h1F);
    check("async_rst_zero",  64'(zero), 64'd1);
    $display("[TB] async reset: valid=%0d index=%0h zero=%0d", out_valid, index, zero);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    tick();

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 512; i++) begin
      word     = 9'(i);
      in_valid = 1'b1;
      a        = word;
      tick();
      ref_idx = lod_ref(64'(word), 9);
      check("sweep_valid", 64'(out_valid), 64'd1);
      check("sweep_index", 64'(index), (ref_idx < 0) ? 64'h1F : 64'(ref_idx));
      check("sweep_zero",  64'(zero), (word == 9'd0) ? 64'd1 : 64'd0);
    end
    $display("[TB] exhaustive sweep of 512 words done");

    // Valid gating: index/zero hold while out_valid is low.
    vec("gate_first", 9'h010, 5'd4, 1'b0);
    in_valid = 1'b0;
    a        = 9'h1FF;
    tick();
    check("gap1_valid", 64'(out_valid), 64'd0);
    check("gap1_index", 64'(index), 64'd4);
    check("gap1_zero",  64'(zero), 64'd0);
    $display("[TB] gap1 valid=%0d index=%0d", out_valid, index);
    a = 9'h000;
    tick();
    check("gap2_valid", 64'(out_valid), 64'd0);
    check("gap2_index", 64'(index), 64'd4);
    check("gap2_zero",  64'(zero), 64'd0);
    $display("[TB] gap2 valid=%0d index=%0d", out_valid, index);
    vec("gate_last", 9'h002, 5'd1, 1'b0);
    in_valid = 1'b0;

    // Other parameterisations.
    in_valid16 = 1'b1; a16 = 16'h8000;
    in_valid2  = 1'b1; a2  = 2'b01;
    tick();
    check("w16_msb_valid", 64'(out_valid16), 64'd1);
    check("w16_msb_index", 64'(index16), 64'd15);
    check("w16_msb_zero",  64'(zero16), 64'd0);
    check("w2_lsb_index",  64'(index2), 64'd0);
    check("w2_lsb_zero",   64'(zero2), 64'd0);
    $display("[TB] w16 a=8000 index=%0d; w2 a=01 index=%0d", index16, index2);
    a16 = 16'h0000;
    a2  = 2'b00;
    tick();
    check("w16_zero_index", 64'(index16), 64'h1F);
    check("w16_zero_zero",  64'(zero16), 64'd1);
    check("w2_zero_index",  64'(index2), 64'h3);
    check("w2_zero_zero",   64'(zero2), 64'd1);
    $display("[TB] w16 a=0000 index=%0h; w2 a=00 index=%0h", index16, index2);
    a16 = 16'h0123;
    a2  = 2'b10;
    tick();
    check("w16_mid_index", 64'(index16), 64'd8);
    check("w2_msb_index",  64'(index2), 64'd1);
    $display("[TB] w16 a=0123 index=%0d; w2 a=10 index=%0d", index16, index2);
    in_valid16 = 1'b0;
    in_valid2  = 1'b0;
    tick();
    check("w16_drop_valid", 64'(out_valid16), 64'd0);
    check("w2_drop_valid",  64'(out_valid2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
